uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller that sequences the `uart_rx` frame decoder and buffers its output. It synchronises the raw serial pin and generates mid-bit `baud_tick` pulses from a phase accumulator governed by the decoder's `phase_accum_reset`. Completed frames are queued in a small FIFO behind a valid/ready port, with overflow and frame-error tracking. It sits between the pad/UART decoder and the register or DMA consumer.

## Interface
- `UART_SIZE`, 8, data bits per frame; must match the decoder.
- `FIFO_DEPTH`, 4, number of FIFO entries; power of two, ≥2.
- `ACC_WIDTH`, 16, phase accumulator width.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_pin`  in  1  raw asynchronous serial input.
- `baud_inc`  in  ACC_WIDTH  accumulator increment per clk, equal to 2^ACC_WIDTH / clocks-per-bit.
- `rx_sync`  out  1  synchronised serial line, driven to decoder `RX`.
- `baud_tick`  out  1  one-cycle sample pulse, driven to the decoder.
- `phase_accum_reset`  in  1  from decoder; 1 = hold accumulator at preload.
- `rx_data`  in  UART_SIZE  from decoder.
- `done`  in  1  from decoder; one-cycle pulse on a good stop bit.
- `crc_error`  in  1  from decoder parity flag.
- `stop_error`  in  1  from decoder stop flag.
- `m_data`  out  UART_SIZE  FIFO head data.
- `m_perr`  out  1  parity-error flag of the FIFO head.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts the head.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a frame was dropped because the FIFO was full.
- `clr_overflow`  in  1  clears `overflow`.
- `frame_err_cnt`  out  8  saturating stop-error count.

## Operation
- Synchroniser: two flops, both reset to 1. `rx_sync` is the second flop, so the pin reaches the decoder 2 cycles late.
- Accumulator: while `phase_accum_reset`=1, `acc` is held at 2^(ACC_WIDTH-1), a half-bit preload. Otherwise `acc <= acc + baud_inc` modulo 2^ACC_WIDTH. The carry-out is registered as `baud_tick`, which is never high for two consecutive cycles unless `baud_inc` ≥ 2^(ACC_WIDTH-1).
- Push: on a cycle with `done`=1, write {`crc_error`, `rx_data`} into the FIFO.
- Pop: on a cycle with `m_valid` & `m_ready`, advance the read pointer. `m_data`/`m_perr` show the head; they hold their last value while empty and are never driven by a combinational path from `done`.
- Full and push without pop: the new frame is dropped, `overflow` is set, and existing contents are unchanged.
- Full and push with pop in the same cycle: both take effect, the level stays at FIFO_DEPTH, and there is no overflow.
- Empty and push with `m_ready`=1: no bypass; the frame becomes visible the next cycle.
- `clr_overflow` together with an overflow event in the same cycle: set wins.
- Frame-error event: a rising edge of `phase_accum_reset` (registered previous value 0, current value 1) with `done`=0 and `stop_error`=1. Each event increments `frame_err_cnt`, which saturates at 255.
- Pointers wrap modulo FIFO_DEPTH. The level is tracked by a separate counter (0..FIFO_DEPTH).

## Timing
- All outputs are registered.
- Reset values: `rx_sync`=1, `baud_tick`=0, `m_valid`=0, `m_data`=0, `m_perr`=0, `fifo_level`=0, `overflow`=0, `frame_err_cnt`=0; `acc` is at preload.
- Assertion of `reset_n` mid-frame empties the FIFO immediately. After deassertion, the first push is possible once the decoder re-frames.
- Latency from `done` to `m_valid`: 1 clk. `fifo_level` updates on the same edge.
- Tick spacing: exactly 2^ACC_WIDTH / `baud_inc` cycles when this divides evenly; otherwise ticks dither by ±1 cycle.
- First tick is at half a bit period after `phase_accum_reset` first samples 0.
- A change of `baud_inc` takes effect on the next add; `acc` is not reloaded.

## Configuration
- `UART_RX_CTRL_ERR_CNT_EN` defined: the frame-error edge detector and `frame_err_cnt` counter are present, as described above.
- `UART_RX_CTRL_ERR_CNT_EN` undefined: the logic is removed, `frame_err_cnt` is tied to 0, and all other behaviour is identical.

## Test plan
- ACC_WIDTH=16, `baud_inc`=0x1000: drop `phase_accum_reset` and hold it at 0 → first `baud_tick` 8 cycles later, then every 16 cycles; raise `phase_accum_reset` → no further ticks.
- Drive `rx_pin` 1→0 → `rx_sync` falls exactly 2 clks later.
- `done` with `rx_data`=0xA5, `crc_error`=1 → next cycle `m_valid`=1, `m_data`=0xA5, `m_perr`=1, `fifo_level`=1; pulse `m_ready` → `m_valid`=0.
- FIFO_DEPTH=4, `m_ready`=0, push 0x01..0x05 → `fifo_level`=4 and `overflow`=1; pop order is 0x01,0x02,0x03,0x04; pushing 0x06 while full with `m_ready`=1 → 0x06 accepted and `overflow` unchanged.
- `clr_overflow` in the same cycle as an overflowing push → `overflow` stays 1; `clr_overflow` alone → `overflow`=0.
- With macro defined: 3 rising edges of `phase_accum_reset` with `stop_error`=1 and `done`=0 → `frame_err_cnt`=3; 300 such edges → 255. Assert `reset_n` low mid-burst → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// Valid/ready stream carrying received UART frames from the receive
// controller FIFO to its consumer (register block or DMA).
//
// Signals:
//   m_data   frame data at the FIFO head
//   m_perr   parity-error flag stored with the head frame
//   m_valid  FIFO holds at least one frame
//   m_ready  consumer accepts the head frame this cycle
//
// Modports:
//   master   the FIFO side (drives data/perr/valid, samples ready)
//   slave    the consumer side
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
    parameter int UART_SIZE = 8
) ();

    logic [UART_SIZE-1:0] m_data;
    logic                 m_perr;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output m_data,
        output m_perr,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_perr,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side controller wrapped around the uart_rx frame decoder.
// Synchronises the serial pin, produces mid-bit baud ticks from a phase
// accumulator, and queues decoded frames in a small FIFO presented on a
// valid/ready stream with overflow and frame-error tracking.
//
// Optional feature macro: UART_RX_CTRL_ERR_CNT_EN
//   defined   -> frame-error edge detector and saturating counter present
//   undefined -> o_frame_err_cnt is tied to zero
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   i_rx_pin               raw asynchronous serial input
//   i_baud_inc             accumulator increment (2^ACC_WIDTH / clocks-per-bit)
//   o_rx_sync              synchronised serial line to the decoder
//   o_baud_tick            one-cycle sample pulse to the decoder
//   i_phase_accum_reset    decoder request to hold the accumulator at preload
//   i_rx_data, i_done      decoder frame data and good-stop-bit pulse
//   i_crc_error            decoder parity flag, stored with each frame
//   i_stop_error           decoder stop-bit error flag
//   m_if                   frame stream (master modport)
//   o_fifo_level           FIFO occupancy, 0..FIFO_DEPTH
//   o_overflow             sticky dropped-frame flag
//   i_clr_overflow         clears o_overflow
//   o_frame_err_cnt        saturating stop-error event count
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int UART_SIZE  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_rx_pin,
    input  logic [ACC_WIDTH-1:0]          i_baud_inc,
    output logic                          o_rx_sync,
    output logic                          o_baud_tick,
    input  logic                          i_phase_accum_reset,
    input  logic [UART_SIZE-1:0]          i_rx_data,
    input  logic                          i_done,
    input  logic                          i_crc_error,
    input  logic                          i_stop_error,
    uart_rx_ctrl_if.master                m_if,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    input  logic                          i_clr_overflow,
    output logic [7:0]                    o_frame_err_cnt
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = UART_SIZE + 1;

    localparam logic [LVL_W-1:0]     LVL_FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [ACC_WIDTH-1:0] ACC_PRELOAD = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                 r_syncMeta;
    logic                 r_syncOut;
    logic [ACC_WIDTH-1:0] r_accum;
    logic                 r_tick;
    logic [ACC_WIDTH:0]   w_accSum;

    logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [PTR_W-1:0]     w_rdPtrNext;
    logic [LVL_W-1:0]     r_level;
    logic [LVL_W-1:0]     w_levelNext;
    logic                 r_valid;
    logic [UART_SIZE-1:0] r_headData;
    logic                 r_headPerr;
    logic                 r_overflow;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_pushEntry;
    logic [ENTRY_W-1:0]   w_headNext;

    // Two-flop synchroniser; both stages idle high like a quiet UART line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_syncMeta <= 1'b1;
            r_syncOut  <= 1'b1;
        end else begin
            r_syncMeta <= i_rx_pin;
            r_syncOut  <= r_syncMeta;
        end
    end

    assign o_rx_sync = r_syncOut;

    // Phase accumulator. The half-scale preload puts the first carry half a
    // bit after release, so ticks land mid-bit. The carry is the tick.
    assign w_accSum = {1'b0, r_accum} + {1'b0, i_baud_inc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_accum <= ACC_PRELOAD;
            r_tick  <= 1'b0;
        end else if (i_phase_accum_reset) begin
            r_accum <= ACC_PRELOAD;
            r_tick  <= 1'b0;
        end else begin
            r_accum <= w_accSum[ACC_WIDTH-1:0];
            r_tick  <= w_accSum[ACC_WIDTH];
        end
    end

    assign o_baud_tick = r_tick;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop       = r_valid & m_if.m_ready;
    assign w_full      = (r_level == LVL_FULL);
    assign w_push      = i_done & (~w_full | w_pop);
    assign w_drop      = i_done & w_full & ~w_pop;
    assign w_pushEntry = {i_crc_error, i_rx_data};
    assign w_rdPtrNext = w_pop ? r_rdPtr + PTR_W'(1) : r_rdPtr;

    // Occupancy after this edge.
    always_comb begin
        w_levelNext = r_level;
        if (w_push && !w_pop) begin
            w_levelNext = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_levelNext = r_level - LVL_W'(1);
        end
    end

    // Head register contents after this edge. When the pushed entry becomes
    // the head it is taken from the push path, since the memory write lands
    // on the same edge. An emptied FIFO keeps showing the last head.
    always_comb begin
        w_headNext = {r_headPerr, r_headData};
        if (w_levelNext != '0) begin
            if (w_push && (r_wrPtr == w_rdPtrNext)) begin
                w_headNext = w_pushEntry;
            end else begin
                w_headNext = r_mem[w_rdPtrNext];
            end
        end
    end

    // Storage needs no reset: validity is governed by the level counter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_pushEntry;
        end
    end

    // Pointers, level, registered head and the sticky overflow flag, where a
    // dropped frame beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_headData <= '0;
            r_headPerr <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            r_rdPtr                  <= w_rdPtrNext;
            r_level                  <= w_levelNext;
            r_valid                  <= (w_levelNext != '0);
            {r_headPerr, r_headData} <= w_headNext;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign m_if.m_data  = r_headData;
    assign m_if.m_perr  = r_headPerr;
    assign m_if.m_valid = r_valid;
    assign o_fifo_level = r_level;
    assign o_overflow   = r_overflow;

`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic       r_parPrev;
    logic [7:0] r_errCnt;
    logic       w_frameErr;

    // The decoder re-arms the accumulator when it abandons a frame; a rising
    // edge without a good stop bit but with a stop error is a framing error.
    assign w_frameErr = ~r_parPrev & i_phase_accum_reset & ~i_done & i_stop_error;

    // Previous-value register starts high so release from reset with the
    // decoder idle is not mistaken for an edge. Counter saturates at 255.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parPrev <= 1'b1;
            r_errCnt  <= 8'd0;
        end else begin
            r_parPrev <= i_phase_accum_reset;
            if (w_frameErr && (r_errCnt != 8'hFF)) begin
                r_errCnt <= r_errCnt + 8'd1;
            end
        end
    end

    assign o_frame_err_cnt = r_errCnt;
`else
    logic w_unusedStopError;

    assign w_unusedStopError = i_stop_error;
    assign o_frame_err_cnt   = 8'd0;
`endif

endmodule
